// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: icodes, register IDs, status codes and the
// D->E pipeline register layout with its bubble value.
package y86_pkg;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVX  = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef struct packed {
    logic [1:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valC;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
  } ereg_t;

  localparam ereg_t E_BUBBLE = '{
    stat:  STAT_AOK,
    icode: I_NOP,
    ifun:  4'h0,
    valC:  64'h0,
    valA:  64'h0,
    valB:  64'h0,
    dstE:  RNONE,
    dstM:  RNONE,
    srcA:  RNONE,
    srcB:  RNONE
  };

  // Instructions whose memory result lands in dstM one stage too late to forward.
  function automatic logic is_load(input logic [3:0] icode);
    return (icode == I_MRMOVQ) || (icode == I_POPQ);
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// One five-source priority forwarding mux: newest in-flight producer wins,
// falling back to the register file value.
module fwd_sel
  import y86_pkg::*;
(
  input  logic [3:0]  src_i,
  input  logic [63:0] rf_val_i,
  input  logic [3:0]  e_dstE_i,
  input  logic [63:0] e_valE_i,
  input  logic [3:0]  M_dstM_i,
  input  logic [63:0] m_valM_i,
  input  logic [3:0]  M_dstE_i,
  input  logic [63:0] M_valE_i,
  input  logic [3:0]  W_dstM_i,
  input  logic [63:0] W_valM_i,
  input  logic [3:0]  W_dstE_i,
  input  logic [63:0] W_valE_i,
  output logic [63:0] val_o
);

  // Priority order is execute, memory (M before E), writeback (M before E).
  always_comb begin
    val_o = rf_val_i;
    if (src_i == RNONE)         val_o = rf_val_i;
    else if (src_i == e_dstE_i) val_o = e_valE_i;
    else if (src_i == M_dstM_i) val_o = m_valM_i;
    else if (src_i == M_dstE_i) val_o = M_valE_i;
    else if (src_i == W_dstM_i) val_o = W_valM_i;
    else if (src_i == W_dstE_i) val_o = W_valE_i;
    else                        val_o = rf_val_i;
  end

endmodule

// File: rtl/decode_forward_ereg.sv
// Y86-64 decode back end: register ID decode, operand forwarding, hazard
// control, the D->E pipeline register and stall/bubble counters.
module decode_forward_ereg
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       D_stat,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       D_ifun,
  input  logic [3:0]       D_rA,
  input  logic [3:0]       D_rB,
  input  logic [63:0]      D_valC,
  input  logic [63:0]      D_valP,
  input  logic [63:0]      rf_valA,
  input  logic [63:0]      rf_valB,
  input  logic [3:0]       e_dstE,
  input  logic [63:0]      e_valE,
  input  logic             e_cnd,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       M_dstE,
  input  logic [63:0]      M_valE,
  input  logic [3:0]       M_dstM,
  input  logic [63:0]      m_valM,
  input  logic [3:0]       W_dstE,
  input  logic [63:0]      W_valE,
  input  logic [3:0]       W_dstM,
  input  logic [63:0]      W_valM,
  output logic [3:0]       d_srcA,
  output logic [3:0]       d_srcB,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic [1:0]       E_stat,
  output logic [3:0]       E_icode,
  output logic [3:0]       E_ifun,
  output logic [63:0]      E_valC,
  output logic [63:0]      E_valA,
  output logic [63:0]      E_valB,
  output logic [3:0]       E_dstE,
  output logic [3:0]       E_dstM,
  output logic [3:0]       E_srcA,
  output logic [3:0]       E_srcB,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ereg_t            e_q, e_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [3:0]       d_dstE, d_dstM;
  logic [63:0]      fwd_a, fwd_b, d_valA;
  logic             loaduse, ret_haz, mispred, E_bubble;

  // Register ID decode from the D register.
  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    d_dstE = RNONE;
    d_dstM = RNONE;
    case (D_icode)
      I_CMOVX, I_RMMOVQ, I_OPQ, I_PUSHQ: d_srcA = D_rA;
      I_RET, I_POPQ:                     d_srcA = RSP;
      default:                           d_srcA = RNONE;
    endcase
    case (D_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:         d_srcB = D_rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:    d_srcB = RSP;
      default:                           d_srcB = RNONE;
    endcase
    case (D_icode)
      I_CMOVX, I_IRMOVQ, I_OPQ:          d_dstE = D_rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:    d_dstE = RSP;
      default:                           d_dstE = RNONE;
    endcase
    case (D_icode)
      I_MRMOVQ, I_POPQ:                  d_dstM = D_rA;
      default:                           d_dstM = RNONE;
    endcase
  end

  fwd_sel u_fwd_a (
    .src_i(d_srcA), .rf_val_i(rf_valA),
    .e_dstE_i(e_dstE), .e_valE_i(e_valE),
    .M_dstM_i(M_dstM), .m_valM_i(m_valM),
    .M_dstE_i(M_dstE), .M_valE_i(M_valE),
    .W_dstM_i(W_dstM), .W_valM_i(W_valM),
    .W_dstE_i(W_dstE), .W_valE_i(W_valE),
    .val_o(fwd_a)
  );

  fwd_sel u_fwd_b (
    .src_i(d_srcB), .rf_val_i(rf_valB),
    .e_dstE_i(e_dstE), .e_valE_i(e_valE),
    .M_dstM_i(M_dstM), .m_valM_i(m_valM),
    .M_dstE_i(M_dstE), .M_valE_i(M_valE),
    .W_dstM_i(W_dstM), .W_valM_i(W_valM),
    .W_dstE_i(W_dstE), .W_valE_i(W_valE),
    .val_o(fwd_b)
  );

  // Jumps and calls carry the fall-through/return PC in valA.
  always_comb begin
    d_valA = fwd_a;
    if ((D_icode == I_JXX) || (D_icode == I_CALL)) d_valA = D_valP;
    else                                           d_valA = fwd_a;
  end

  // Hazard detection from current inputs and E register contents.
  always_comb begin
    loaduse  = is_load(e_q.icode) && (e_q.dstM != RNONE) &&
               ((e_q.dstM == d_srcA) || (e_q.dstM == d_srcB));
    ret_haz  = (D_icode == I_RET) || (e_q.icode == I_RET) || (M_icode == I_RET);
    mispred  = (e_q.icode == I_JXX) && !e_cnd;
    F_stall  = loaduse || ret_haz;
    D_stall  = loaduse;
    D_bubble = mispred || (ret_haz && !loaduse);
    E_bubble = mispred || loaduse;
  end

  // Next E register value and saturating counter updates.
  always_comb begin
    e_d          = E_BUBBLE;
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (E_bubble) begin
      e_d = E_BUBBLE;
    end else begin
      e_d = '{stat: D_stat, icode: D_icode, ifun: D_ifun, valC: D_valC,
              valA: d_valA, valB: fwd_b, dstE: d_dstE, dstM: d_dstM,
              srcA: d_srcA, srcB: d_srcB};
    end
    if (D_stall && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_ONE;
    else                                     stall_cnt_d = stall_cnt_q;
    if (E_bubble && (bubble_cnt_q != CNT_MAX)) bubble_cnt_d = bubble_cnt_q + CNT_ONE;
    else                                       bubble_cnt_d = bubble_cnt_q;
  end

  // E register and counters; the E register never stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q          <= E_BUBBLE;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      e_q          <= e_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign E_stat     = e_q.stat;
  assign E_icode    = e_q.icode;
  assign E_ifun     = e_q.ifun;
  assign E_valC     = e_q.valC;
  assign E_valA     = e_q.valA;
  assign E_valB     = e_q.valB;
  assign E_dstE     = e_q.dstE;
  assign E_dstM     = e_q.dstM;
  assign E_srcA     = e_q.srcA;
  assign E_srcB     = e_q.srcB;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule
